minotirty: RTL and testbench

MINOTIRTY -- requirements
Module: minotirty

---
 rtl/minority_pkg.sv | 12 +
 rtl/minotirty_popcount3.sv | 12 +
 rtl/minotirty.sv | 47 ++++
 tb/tb_minotirty.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/minority_pkg.sv
// Shared constants and voter helper for the minority block.
// Latency: n/a (definitions only). Backpressure: n/a.
// maj3 is the single source of the majority function that y is derived from.
package minority_pkg;

    localparam int CNT_W_DEF = 16;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/minotirty_popcount3.sv
// Counts how many of three single-bit inputs are high (0..3).
// Latency: combinational. Backpressure: none.
module popcount3 (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic [1:0] count
);

    assign count = {1'b0, a} + {1'b0, b} + {1'b0, c};

endmodule

// File: rtl/minotirty.sv
// Three-input minority voter with a registered copy and a saturating minority-cycle counter.
// Latency: y/ones combinational; y_q and min_cnt update one clk edge later. Backpressure: none.
module minotirty
    import minority_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             clr,
    output logic             y,
    output logic [1:0]       ones,
    output logic             y_q,
    output logic [CNT_W-1:0] min_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    popcount3 u_popcount3 (
        .a     (a),
        .b     (b),
        .c     (c),
        .count (ones)
    );

    // Minority is the complement of majority; equivalent to ones < 2.
    assign y = ~maj3(a, b, c);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q     <= 1'b0;
            min_cnt <= '0;
        end else begin
            y_q <= y;
            if (clr) begin
                min_cnt <= '0;
            end else if (y && (min_cnt != CNT_MAX)) begin
                min_cnt <= min_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_minotirty.sv
// Randomized self-checking bench for minotirty against an arithmetic reference model.
module tb_minotirty;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        reset, a, b, c, clr;
    logic        y, y2, y_q, y_q2;
    logic [1:0]  ones, ones2;
    logic [15:0] min_cnt;
    logic [1:0]  min_cnt2;

    int n_checks = 0;
    int n_pass   = 0;

    longint m16, m2;
    bit     myq;

    always #5 if (clk_en) clk = ~clk;

    minotirty u_dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .clr(clr),
        .y(y), .ones(ones), .y_q(y_q), .min_cnt(min_cnt)
    );

    minotirty #(.CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .clr(clr),
        .y(y2), .ones(ones2), .y_q(y_q2), .min_cnt(min_cnt2)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int pop3();
        return int'(a) + int'(b) + int'(c);
    endfunction

    task automatic comb_check(input string tag);
        check({tag, ".y"},     longint'(y),     longint'(pop3() < 2));
        check({tag, ".ones"},  longint'(ones),  longint'(pop3()));
        check({tag, ".y2"},    longint'(y2),    longint'(pop3() < 2));
        check({tag, ".ones2"}, longint'(ones2), longint'(pop3()));
    endtask

    task automatic state_check(input string tag);
        check({tag, ".y_q"},     longint'(y_q),      longint'(myq));
        check({tag, ".y_q2"},    longint'(y_q2),     longint'(myq));
        check({tag, ".min_cnt"}, longint'(min_cnt),  m16);
        check({tag, ".cnt_w2"},  longint'(min_cnt2), m2);
    endtask

    // Model one rising edge from the inputs as currently driven.
    task automatic step(input string tag);
        bit yv;
        @(posedge clk);
        yv  = pop3() < 2;
        myq = yv;
        if (clr) begin
            m16 = 0;
            m2  = 0;
        end else if (yv) begin
            if (m16 < 65535) m16++;
            if (m2 < 3) m2++;
        end
        #1;
        state_check(tag);
    endtask

    task automatic do_reset_pulse(input string tag);
        reset = 1'b1;
        #1;
        m16 = 0; m2 = 0; myq = 0;
        state_check(tag);
        comb_check({tag, ".in_rst"});
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; clr = 1'b0; {a, b, c} = 3'b000;
        m16 = 0; m2 = 0; myq = 0;
        #10;
        state_check("reset");

        // All 8 input combinations with no clock running.
        for (int i = 0; i < 8; i++) begin
            {a, b, c} = 3'(i);
            #10;
            comb_check($sformatf("tt%0d", i));
        end

        reset = 1'b0;
        {a, b, c} = 3'b000;
        clk_en = 1'b1;
        for (int i = 0; i < 5; i++) step($sformatf("run000_%0d", i));
        check("after5.min_cnt", longint'(min_cnt), 5);

        {a, b, c} = 3'b110;
        for (int i = 0; i < 3; i++) step($sformatf("hold110_%0d", i));
        check("hold.min_cnt", longint'(min_cnt), 5);

        {a, b, c} = 3'b001; clr = 1'b1;
        step("clr_pri");
        check("clr_pri.zero", longint'(min_cnt), 0);
        clr = 1'b0;
        step("clr_rel");
        check("clr_rel.one", longint'(min_cnt), 1);

        clr = 1'b1;
        step("clr2");
        clr = 1'b0;
        {a, b, c} = 3'b000;
        for (int i = 0; i < 7; i++) step($sformatf("sat_%0d", i));
        check("sat.cnt_w2", longint'(min_cnt2), 3);
        check("seven.min_cnt", longint'(min_cnt), 7);

        // Async reset between edges; y must keep tracking inputs.
        #2;
        reset = 1'b1;
        #1;
        m16 = 0; m2 = 0; myq = 0;
        state_check("midrst");
        {a, b, c} = 3'b111;
        #1;
        comb_check("midrst111");
        {a, b, c} = 3'b100;
        #1;
        comb_check("midrst100");
        reset = 1'b0;

        for (int i = 0; i < 300; i++) begin
            {a, b, c} = 3'($urandom_range(0, 7));
            clr = ($urandom_range(0, 9) == 0);
            #1;
            comb_check("rnd");
            if ($urandom_range(0, 19) == 0) do_reset_pulse("rnd_rst");
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
